// File: rtl/dac_channel_scheduler.sv
// Four-channel DAC write scheduler: captures per-channel values, grants them
// round-robin and sequences one serializer transfer at a time with a timeout.
module dac_channel_scheduler #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [47:0] ch_data,
  output logic [3:0]  ack,
  output logic [3:0]  pending,
  output logic        dac_start,
  output logic [3:0]  dac_command,
  output logic [3:0]  dac_address,
  output logic [11:0] dac_data,
  input  logic        dac_done,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;

  localparam logic [7:0] TO_CNT  = 8'(TIMEOUT_CYCLES);
  localparam logic [3:0] CMD_WRU = 4'b0011;

  state_e           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0][11:0] hold_q, hold_d;
  logic [3:0]       ack_q, ack_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [3:0]       addr_q, addr_d;
  logic [11:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d, cnt_nxt;
  logic [1:0]       last_q, last_d;

  logic             found;
  logic [1:0]       gnt, idx;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    gnt   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k < 5; k++) begin
      idx = last_q + 2'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    ack_d   = 4'b0000;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cnt_nxt = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = LOAD;
          addr_d      = {2'b00, gnt};
          data_d      = hold_q[gnt];
          cmd_d       = CMD_WRU;
          ack_d[gnt]  = 1'b1;
          pend_d[gnt] = 1'b0;
          last_d      = gnt;
        end
      end
      LOAD:  state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d   = 8'd0;
      end
      WAIT: begin
        if (dac_done) begin
          state_d = IDLE;
        end else if (cnt_nxt == TO_CNT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
    // Capture comes last so a same-cycle request beats the grant's clear.
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        pend_d[i] = 1'b1;
        hold_d[i] = ch_data[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      hold_q  <= '0;
      ack_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign ack         = ack_q;
  assign pending     = pend_q;
  assign dac_start   = (state_q == START);
  assign dac_command = cmd_q;
  assign dac_address = addr_q;
  assign dac_data    = data_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: doc/dac_channel_scheduler.md
DAC_CHANNEL_SCHEDULER -- requirements
Module: dac_channel_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles allowed before a transfer is abandoned (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 4 bits: per-channel write request (A=bit0 .. D=bit3), sampled every cycle.
REQ-005 SHALL have port ch_data, input, 48 bits: 12-bit value per channel, channel i at bits [12i+11:12i].
REQ-006 SHALL have port ack, output, 4 bits: one-cycle pulse on bit i when channel i's pending value is granted.
REQ-007 SHALL have port pending, output, 4 bits: bit i is 1 while channel i holds an unsent value.
REQ-008 SHALL have port dac_start, output, 1 bit: one-cycle pulse that starts one serializer transfer.
REQ-009 SHALL have port dac_command, output, 4 bits: serializer command.
REQ-010 SHALL have port dac_address, output, 4 bits: serializer channel address.
REQ-011 SHALL have port dac_data, output, 12 bits: serializer data word.
REQ-012 SHALL have port dac_done, input, 1 bit: one-cycle completion pulse from the serializer.
REQ-013 SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.
REQ-014 SHALL have port err_timeout, output, 1 bit: sticky flag, set when a transfer times out.

Function
REQ-015 Capture: on any cycle with req[i]=1, SHALL load hold[i] from the ch_data slice and set pend[i]=1; a newer request overwrites an unsent value (latest wins, no error).
REQ-016 SHALL drive pending equal to pend, registered.
REQ-017 SHALL run an FSM with states IDLE, LOAD, START, WAIT.
REQ-018 In IDLE with pend≠0, SHALL grant round-robin: search starts at (last_grant+1) mod 4; the first set pend bit wins; the FSM moves to LOAD.
REQ-019 On the IDLE->LOAD edge, SHALL register dac_address=grant index (A=0000 .. D=0011), dac_data=hold[g], dac_command=0011 (write and update), pulse ack[g] for one cycle, clear pend[g], and set last_grant=g.
REQ-020 If req[g] is asserted in the same cycle pend[g] is cleared, capture SHALL win: pend[g] stays 1 with the new data, and the granted transfer carries the old hold[g].
REQ-021 LOAD->START unconditionally; dac_start SHALL be 1 only while in START (exactly one cycle per grant).
REQ-022 START->WAIT; the timeout counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-023 In WAIT, dac_done=1 SHALL return the FSM to IDLE on the next edge.
REQ-024 In WAIT, if the counter reaches TIMEOUT_CYCLES without dac_done, SHALL set err_timeout=1 and return to IDLE; the abandoned value is not re-queued.
REQ-025 dac_done outside WAIT SHALL be ignored.
REQ-026 dac_address, dac_data and dac_command SHALL hold stable from LOAD until the next grant.
REQ-027 Latency: req in cycle N with the FSM idle and no other pend SHALL produce ack in cycle N+2 and dac_start in cycle N+3.
REQ-028 Minimum spacing between dac_start pulses SHALL be 4 cycles (START, WAIT with done, IDLE, LOAD).
REQ-029 err_timeout SHALL clear only on reset.

Reset
REQ-030 With rst_n=0 at a clock edge, SHALL set: state=IDLE; pend=0; hold=0; ack=0; pending=0; dac_start=0; dac_command=0000; dac_address=0000; dac_data=0; busy=0; err_timeout=0; counter=0; last_grant=3 (so channel A has first priority).
REQ-031 Reset asserted mid-transfer SHALL abort the transfer immediately, with no ack, no dac_start, and no re-queue after release.
REQ-032 req SHALL be ignored during reset.

Verification
REQ-033 Single request: req=0001, ch_data[11:0]=0xABC, idle -> ack=0001 at N+2; dac_start at N+3 with address=0000, data=0xABC, command=0011; busy is 0 after dac_done.
REQ-034 Round-robin: req=1111 in one cycle with distinct data, dac_done 2 cycles after each start -> grant order A,B,C,D; a second req=1111 -> order A,B,C,D again.
REQ-035 Overwrite: channel C req with 0x111, then 0x222 while channel A is in WAIT -> one channel C transfer with data=0x222; pending[2] clears at its ack.
REQ-036 Timeout: TIMEOUT_CYCLES=8, dac_done held 0 -> err_timeout=1 after 8 WAIT cycles; FSM returns to IDLE and the next pend is granted normally.
REQ-037 Collision: req[1] asserted in the same cycle channel B is granted -> the transfer carries the old data, pending[1] stays 1, and a second transfer carries the new data.
REQ-038 Reset in WAIT: rst_n=0 for 1 cycle -> all outputs at reset values next edge; a stray dac_done afterwards has no effect.
